// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-RAM arbiter and the RAM model.
package mips_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} arb_state_e;
  typedef enum logic {GNT_I, GNT_D} grant_e;

  localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; counts RAM wait states.
module mem_wait_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified RAM between instruction fetch and load/store,
// one fixed-latency access at a time, and generates the pipeline stalls.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stall_if,
  output logic              stall_pipe,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              wr_q;
  logic              if_ready_q, mem_ready_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              d_pend, sel_data, issue, cnt_zero, finish;

  // IF only wins a tie when data had the previous grant.
  assign d_pend   = mem_read | mem_write;
  assign sel_data = d_pend & ~(if_req & (last_grant_q == GNT_D));
  assign issue    = (state_q == IDLE) & (if_req | d_pend) & ~RST;
  assign finish   = (state_q == WAIT) & cnt_zero;

  assign ram_en    = issue;
  assign ram_we    = issue & sel_data & mem_write;
  assign ram_addr  = sel_data ? mem_addr : if_addr;
  assign ram_wdata = sel_data ? mem_wdata : '0;

  mem_wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (issue),
    .load_val_i(LOAD_VAL),
    .dec_i     (state_q == WAIT),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d      = WAIT;
          last_grant_d = sel_data ? GNT_D : GNT_I;
        end
      end
      WAIT:    if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      wr_q         <= 1'b0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (issue) begin
        wr_q <= sel_data & mem_write;
      end
      if_ready_q  <= finish & (last_grant_q == GNT_I);
      mem_ready_q <= finish & (last_grant_q == GNT_D);
      // Capture on the last wait cycle; stores leave the read register alone.
      if (finish && !wr_q) begin
        if (last_grant_q == GNT_I) begin
          if_rdata_q <= ram_rdata;
        end else begin
          mem_rdata_q <= ram_rdata;
        end
      end
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_ready   = if_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ready  = mem_ready_q;
  assign stall_if   = if_req & ~if_ready_q;
  assign stall_pipe = d_pend & ~mem_ready_q;

endmodule
